// File: rtl/mipi_csi_tx_raw10_packer_16b2lane_pkg.sv
// Shared CSI-2 RAW packing definitions for the TX packer and the RX depacker model.
// Holds data-type codes, byte/pixel geometry and the RAW10 group packing function.
package mipi_csi_tx_raw10_packer_16b2lane_pkg;

  localparam logic [7:0] CSI_DT_RAW10 = 8'h2B;
  localparam logic [7:0] CSI_DT_RAW12 = 8'h2C;
  localparam logic [7:0] CSI_DT_RAW14 = 8'h2D;

  localparam int PIXELS_PER_BEAT = 4;
  localparam int PIXEL_WIDTH     = 16;
  localparam int RAW10_BITS      = 10;
  localparam int GROUP_BYTES     = 5;
  localparam int WORD_BYTES      = 8;
  localparam int ACC_BYTES       = 16;

  // Highest fill level that still leaves room for a whole 5-byte group.
  localparam logic [4:0] PUSH_LIMIT = 5'(ACC_BYTES - GROUP_BYTES);

  typedef enum logic {
    ST_ACCUM,
    ST_FLUSH
  } packer_state_e;

  // Four MSB-aligned pixels become four MSB bytes followed by one byte of packed LSB pairs.
  function automatic logic [39:0] pack_raw10_group(input logic [63:0] px);
    logic [39:0] grp;
    logic [RAW10_BITS-1:0] p;
    grp = '0;
    for (int n = 0; n < PIXELS_PER_BEAT; n++) begin
      p = px[PIXEL_WIDTH*n + (PIXEL_WIDTH - RAW10_BITS) +: RAW10_BITS];
      grp[8*n +: 8] = p[9:2];
      grp[32 + 2*n +: 2] = p[1:0];
    end
    return grp;
  endfunction

endpackage

// File: rtl/mipi_csi_tx_raw10_packer_16b2lane_accumulator.sv
// 16-byte shift buffer: appends 5-byte groups above the fill level and drains up to 8 bytes from the bottom.
// Bytes above the fill level are always zero, so a new group can simply be OR-ed into place.
module mipi_tx_byte_accumulator
  import mipi_csi_tx_raw10_packer_16b2lane_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        push_i,
  input  logic [39:0] push_bytes_i,
  input  logic        pop_i,
  output logic [63:0] word_o,
  output logic [7:0]  keep_o,
  output logic [4:0]  count_o
);

  logic [8*ACC_BYTES-1:0] buf_q, buf_d;
  logic [4:0] count_q, count_d;
  logic [4:0] pop_n;
  logic [4:0] base;
  logic [3:0] avail;
  logic [8:0] keep_ones;

  // A pop takes a full word, or whatever is left when fewer than 8 bytes remain.
  always_comb begin
    pop_n = 5'd0;
    if (pop_i) begin
      pop_n = (count_q >= 5'(WORD_BYTES)) ? 5'(WORD_BYTES) : count_q;
    end
    base    = count_q - pop_n;
    buf_d   = buf_q >> {pop_n, 3'b000};
    count_d = base;
    if (push_i) begin
      buf_d   = buf_d | ({88'd0, push_bytes_i} << {base, 3'b000});
      count_d = 5'(base + 5'(GROUP_BYTES));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_q   <= '0;
      count_q <= 5'd0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    avail     = (count_q >= 5'(WORD_BYTES)) ? 4'(WORD_BYTES) : count_q[3:0];
    keep_ones = (9'd1 << avail) - 9'd1;
  end

  assign word_o  = buf_q[63:0];
  assign keep_o  = keep_ones[7:0];
  assign count_o = count_q;

endmodule

// File: rtl/mipi_csi_tx_raw10_packer_16b2lane.sv
// RAW10 packer: 4 pixels per beat in, 8-byte CSI-2 words out, with per-line byte count.
// ACCUM emits only full words; FLUSH drains the tail of a line and marks its final word.
module mipi_csi_tx_raw10_packer_16b2lane
  import mipi_csi_tx_raw10_packer_16b2lane_pkg::*;
#(
  parameter int WC_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                pixel_valid_i,
  output logic                pixel_ready_o,
  input  logic [63:0]         pixel_i,
  input  logic                line_end_i,
  output logic                output_valid_o,
  input  logic                output_ready_i,
  output logic [63:0]         output_o,
  output logic [7:0]          output_keep_o,
  output logic                output_last_o,
  output logic [WC_WIDTH-1:0] line_bytes_o
);

  packer_state_e state_q, state_d;
  logic [WC_WIDTH-1:0] line_bytes_q;
  logic [63:0] acc_word;
  logic [7:0]  acc_keep;
  logic [4:0]  acc_count;
  logic [39:0] group_bytes;
  logic        push;
  logic        pop;

  assign group_bytes = pack_raw10_group(pixel_i);
  assign push        = pixel_valid_i & pixel_ready_o;
  assign pop         = output_valid_o & output_ready_i;

  mipi_tx_byte_accumulator u_acc (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .push_i       (push),
    .push_bytes_i (group_bytes),
    .pop_i        (pop),
    .word_o       (acc_word),
    .keep_o       (acc_keep),
    .count_o      (acc_count)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs depend only on registered state, so they hold steady through a stall.
  always_comb begin
    pixel_ready_o  = 1'b0;
    output_valid_o = 1'b0;
    output_keep_o  = 8'h00;
    output_last_o  = 1'b0;
    state_d        = state_q;
    case (state_q)
      ST_ACCUM: begin
        pixel_ready_o  = (acc_count <= PUSH_LIMIT);
        output_valid_o = (acc_count >= 5'(WORD_BYTES));
        output_keep_o  = output_valid_o ? 8'hFF : 8'h00;
        if (pixel_valid_i && pixel_ready_o && line_end_i) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        output_valid_o = (acc_count != 5'd0);
        output_last_o  = output_valid_o && (acc_count <= 5'(WORD_BYTES));
        output_keep_o  = output_valid_o ? acc_keep : 8'h00;
        if (output_valid_o && output_ready_i && output_last_o) begin
          state_d = ST_ACCUM;
        end
      end
      default: ;
    endcase
  end

  // The count stays visible from the closing beat until the final word leaves.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      line_bytes_q <= '0;
    end else if (pop && output_last_o) begin
      line_bytes_q <= '0;
    end else if (push) begin
      line_bytes_q <= line_bytes_q + WC_WIDTH'(GROUP_BYTES);
    end
  end

  assign output_o     = acc_word;
  assign line_bytes_o = line_bytes_q;

endmodule

// File: tb/tb_mipi_csi_tx_raw10_packer_16b2lane.sv
// Bench for the RAW10 packer: byte-queue model checked every cycle, plus hand-computed words per line.
// An RX depacker model recovers pixels from the emitted bytes for a loopback check.
module tb_mipi_csi_tx_raw10_packer_16b2lane;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        pixel_valid_i;
  logic        pixel_ready_o;
  logic [63:0] pixel_i;
  logic        line_end_i;
  logic        output_valid_o;
  logic        output_ready_i;
  logic [63:0] output_o;
  logic [7:0]  output_keep_o;
  logic        output_last_o;
  logic [15:0] line_bytes_o;

  mipi_csi_tx_raw10_packer_16b2lane #(.WC_WIDTH(16)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .pixel_valid_i  (pixel_valid_i),
    .pixel_ready_o  (pixel_ready_o),
    .pixel_i        (pixel_i),
    .line_end_i     (line_end_i),
    .output_valid_o (output_valid_o),
    .output_ready_i (output_ready_i),
    .output_o       (output_o),
    .output_keep_o  (output_keep_o),
    .output_last_o  (output_last_o),
    .line_bytes_o   (line_bytes_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [15:0] lb;
  } word_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  bit         ended = 1'b0;
  int         line_total = 0;
  int         in_px[$];
  logic [7:0] out_b[$];
  word_t      wlog[$];

  int rdy_mode = 0;
  bit man_rdy  = 1'b0;
  bit tog      = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int p0, input int p1, input int p2, input int p3,
                                     input logic [5:0] lo);
    return {10'(p3), lo, 10'(p2), lo, 10'(p1), lo, 10'(p0), lo};
  endfunction

  function automatic logic [7:0] keep_of(input int n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

  // Downstream ready: always on, toggling, or held at a manual value.
  initial begin
    output_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #2;
      tog = ~tog;
      output_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : man_rdy;
    end
  end

  // Model and compare process: pops are scored before same-edge pushes.
  initial begin
    bit          stall_q;
    logic [63:0] st_d;
    logic [7:0]  st_k;
    logic        st_l;
    bit          exp_valid;
    bit          exp_prdy;
    bit          exp_last;
    int          n;
    int          v;
    logic [63:0] expd;
    logic [63:0] bmask;
    logic [7:0]  ek;
    logic [7:0]  lsb;
    stall_q = 1'b0;
    st_d = '0;
    st_k = '0;
    st_l = 1'b0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        exp_q.delete();
        ended      = 1'b0;
        line_total = 0;
        stall_q    = 1'b0;
      end else begin
        exp_valid = ended ? (exp_q.size() > 0) : (exp_q.size() >= 8);
        exp_prdy  = !ended && (exp_q.size() <= 11);
        checkOutput("output_valid", 64'(output_valid_o), 64'(exp_valid));
        checkOutput("pixel_ready", 64'(pixel_ready_o), 64'(exp_prdy));
        if (stall_q && output_valid_o) begin
          checkOutput("stall_data", output_o, st_d);
          checkOutput("stall_keep", 64'(output_keep_o), 64'(st_k));
          checkOutput("stall_last", 64'(output_last_o), 64'(st_l));
        end
        if (output_valid_o && output_ready_i && exp_valid) begin
          n        = (exp_q.size() >= 8) ? 8 : exp_q.size();
          exp_last = ended && (exp_q.size() <= 8);
          ek       = exp_last ? keep_of(n) : 8'hFF;
          expd     = '0;
          bmask    = '0;
          for (int i = 0; i < n; i++) begin
            expd[8*i +: 8]  = exp_q[i];
            bmask[8*i +: 8] = 8'hFF;
          end
          checkOutput("word_data", output_o & bmask, expd);
          checkOutput("word_keep", 64'(output_keep_o), 64'(ek));
          checkOutput("word_last", 64'(output_last_o), 64'(exp_last));
          if (exp_last) begin
            checkOutput("line_bytes", 64'(line_bytes_o), 64'(16'(line_total)));
          end
          wlog.push_back('{d: output_o, k: output_keep_o, l: output_last_o, lb: line_bytes_o});
          for (int i = 0; i < n; i++) begin
            out_b.push_back(exp_q.pop_front());
          end
          if (exp_last) begin
            ended      = 1'b0;
            line_total = 0;
          end
        end
        stall_q = output_valid_o && !output_ready_i;
        st_d = output_o;
        st_k = output_keep_o;
        st_l = output_last_o;
        if (pixel_valid_i && pixel_ready_o) begin
          lsb = 8'h00;
          for (int i = 0; i < 4; i++) begin
            v = int'(pixel_i[16*i+6 +: 10]);
            in_px.push_back(v);
            exp_q.push_back(8'(v / 4));
            lsb = lsb | 8'((v % 4) << (2*i));
          end
          exp_q.push_back(lsb);
          line_total += 5;
          if (line_end_i) ended = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] px, input logic le);
    bit acc;
    int n;
    pixel_i       = px;
    line_end_i    = le;
    pixel_valid_i = 1'b1;
    n   = 0;
    acc = 1'b0;
    do begin
      @(negedge clk_i);
      acc = pixel_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) checkOutput("beat_accept_timeout", 64'd0, 64'd1);
    pixel_valid_i = 1'b0;
    line_end_i    = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ended) && n < 500) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (n >= 500) checkOutput("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic popOne();
    man_rdy = 1'b1;
    @(posedge clk_i);
    #1;
    man_rdy = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    pixel_valid_i = 1'b0;
    reset_i       = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset_i       = 1'b1;
    pixel_valid_i = 1'b0;
    line_end_i    = 1'b0;
    pixel_i       = '0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_valid", 64'(output_valid_o), 64'd0);
    checkOutput("rst_data", output_o, 64'd0);
    checkOutput("rst_keep", 64'(output_keep_o), 64'd0);
    checkOutput("rst_last", 64'(output_last_o), 64'd0);
    checkOutput("rst_line_bytes", 64'(line_bytes_o), 64'd0);
    checkOutput("rst_pixel_ready", 64'(pixel_ready_o), 64'd1);
    @(posedge clk_i);
    #1;

    // Two-beat line; low 6 bits carry junk that must be dropped.
    wlog.delete();
    applyStimulus(mk(10'h3FF, 10'h000, 10'h2AA, 10'h155, 6'h3F), 1'b0);
    applyStimulus(mk(10'h001, 10'h002, 10'h003, 10'h3FC, 6'h15), 1'b1);
    waitIdle();
    checkOutput("t1_words", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      checkOutput("t1_w0_data", wlog[0].d, 64'h0000_0063_55AA_00FF);
      checkOutput("t1_w0_keep", 64'(wlog[0].k), 64'hFF);
      checkOutput("t1_w0_last", 64'(wlog[0].l), 64'd0);
      checkOutput("t1_w1_data", 64'(wlog[1].d[15:0]), 64'h39FF);
      checkOutput("t1_w1_keep", 64'(wlog[1].k), 64'h03);
      checkOutput("t1_w1_last", 64'(wlog[1].l), 64'd1);
      checkOutput("t1_line_bytes", 64'(wlog[1].lb), 64'd10);
    end

    // 32 pixels land exactly on five full words.
    wlog.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(mk(i*4, i*4+1, 1023-i, 512+i, 6'(i)), i == 7);
    end
    waitIdle();
    checkOutput("t2_words", 64'(wlog.size()), 64'd5);
    if (wlog.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput("t2_keep", 64'(wlog[i].k), 64'hFF);
        checkOutput("t2_last", 64'(wlog[i].l), 64'(i == 4));
      end
      checkOutput("t2_line_bytes", 64'(wlog[4].lb), 64'd40);
    end

    // Toggling downstream ready over a 20-beat line, then loopback through a depacker.
    wlog.delete();
    in_px.delete();
    out_b.delete();
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(mk((i*37) % 1024, (i*101+5) % 1024, (i*211+3) % 1024, 1023 - (i*53) % 1024,
                       6'(i*7)), i == 19);
    end
    waitIdle();
    rdy_mode = 0;
    checkOutput("t3_words", 64'(wlog.size()), 64'd13);
    if (wlog.size() == 13) begin
      checkOutput("t3_tail_keep", 64'(wlog[12].k), 64'h0F);
      checkOutput("t3_line_bytes", 64'(wlog[12].lb), 64'd100);
    end
    checkOutput("t3_byte_total", 64'(out_b.size()), 64'd100);
    if (out_b.size() == 100 && in_px.size() == 80) begin
      for (int g = 0; g < 20; g++) begin
        for (int n = 0; n < 4; n++) begin
          p = int'({out_b[5*g+n], 2'(out_b[5*g+4] >> (2*n))});
          checkOutput("t3_loopback_px", 64'(p), 64'(in_px[4*g+n]));
        end
      end
    end

    // 12-pixel line directly followed by the next line.
    wlog.delete();
    applyStimulus(mk(10'h100, 10'h101, 10'h102, 10'h103, 6'h00), 1'b0);
    applyStimulus(mk(10'h200, 10'h201, 10'h202, 10'h203, 6'h00), 1'b0);
    applyStimulus(mk(10'h300, 10'h301, 10'h302, 10'h303, 6'h00), 1'b1);
    applyStimulus(mk(10'h011, 10'h022, 10'h033, 10'h044, 6'h00), 1'b0);
    applyStimulus(mk(10'h055, 10'h066, 10'h077, 10'h088, 6'h00), 1'b1);
    waitIdle();
    checkOutput("t4_words", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) begin
      checkOutput("t4_l1_keep", 64'(wlog[1].k), 64'h7F);
      checkOutput("t4_l1_last", 64'(wlog[1].l), 64'd1);
      checkOutput("t4_l1_line_bytes", 64'(wlog[1].lb), 64'd15);
      checkOutput("t4_l2_keep", 64'(wlog[3].k), 64'h03);
      checkOutput("t4_l2_line_bytes", 64'(wlog[3].lb), 64'd10);
    end

    // Build up 9 buffered bytes with manual pops, then reset mid-line.
    rdy_mode = 2;
    man_rdy  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    applyStimulus(mk(1, 2, 3, 4, 6'h00), 1'b0);
    applyStimulus(mk(5, 6, 7, 8, 6'h00), 1'b0);
    applyStimulus(mk(9, 10, 11, 12, 6'h00), 1'b0);
    popOne();
    applyStimulus(mk(13, 14, 15, 16, 6'h00), 1'b0);
    popOne();
    applyStimulus(mk(17, 18, 19, 20, 6'h00), 1'b0);
    checkOutput("t5_buffered", 64'(exp_q.size()), 64'd9);
    doReset();
    @(negedge clk_i);
    checkOutput("t5_valid", 64'(output_valid_o), 64'd0);
    checkOutput("t5_pixel_ready", 64'(pixel_ready_o), 64'd1);
    checkOutput("t5_line_bytes", 64'(line_bytes_o), 64'd0);
    checkOutput("t5_keep", 64'(output_keep_o), 64'd0);
    checkOutput("t5_last", 64'(output_last_o), 64'd0);
    @(posedge clk_i);
    #1;
    rdy_mode = 0;
    wlog.delete();
    applyStimulus(mk(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 6'h00), 1'b1);
    waitIdle();
    checkOutput("t5_words", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) begin
      checkOutput("t5_data", 64'(wlog[0].d[39:0]), 64'hFF_FFFF_FFFF);
      checkOutput("t5_w_keep", 64'(wlog[0].k), 64'h1F);
      checkOutput("t5_w_last", 64'(wlog[0].l), 64'd1);
      checkOutput("t5_w_line_bytes", 64'(wlog[0].lb), 64'd5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
